fetch_queue: RTL

- Instruction prefetch stage sitting directly upstream of the processor's F/D latch. It drives the imem address, captures q_imem, and buffers fetched words in a small FIFO.
- Hands the processor one instruction per cycle, tagged with its PC and PC+1, using a valid/ready handshake.
- Supports a single-cycle redirect from the execute stage (taken branch, jump) that flushes all buffered and in-flight words.

---
 rtl/fetch_queue.sv | 108 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue. It sits in front of the F/D latch, drives the
// imem address, captures the synchronous-read data one cycle later, and
// buffers the fetched words together with their PCs in a small FIFO. A
// redirect from execute flushes both the buffered words and the word in flight.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [31:0]              address_imem,
  input  logic [31:0]              q_imem,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_insn,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_pcPlus1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic          req_d1;
  logic [31:0]   req_pc_d1;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   mem_insn [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];

  logic [CW-1:0] occupancy;
  logic          issue;
  logic          push;
  logic          pop;

  // A read is only issued when a slot is guaranteed for it: the words already
  // buffered plus the one in flight must leave room, so a push never overflows.
  assign occupancy    = count + CW'(req_d1);
  assign issue        = (occupancy < CW'(DEPTH)) && !redirect;
  assign push         = req_d1 && !redirect;
  assign pop          = out_valid && out_ready && !redirect;
  assign address_imem = fetch_pc;
  assign out_valid    = (count != '0);

  // Fetch address and the one-deep tracker of the read currently in flight.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc  <= RESET_PC;
      req_d1    <= 1'b0;
      req_pc_d1 <= 32'h0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      req_d1   <= 1'b0;
    end else if (issue) begin
      fetch_pc  <= fetch_pc + 32'd1;
      req_d1    <= 1'b1;
      req_pc_d1 <= fetch_pc;
    end else begin
      req_d1 <= 1'b0;
    end
  end

  // FIFO bookkeeping: pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage, written with the captured imem word and its address.
  // NOTE: the storage array has no reset; an entry is never read unless count
  // says it was written, so clearing it would only cost reset fan-out.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_insn[wr_ptr] <= q_imem;
      mem_pc[wr_ptr]   <= req_pc_d1;
    end
  end

  // Head presentation; all tags read as zero while the queue is empty.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    out_insn    = 32'h0;
    out_pc      = 32'h0;
    out_pcPlus1 = 32'h0;
    if (out_valid) begin
      out_insn    = mem_insn[rd_ptr];
      out_pc      = mem_pc[rd_ptr];
      out_pcPlus1 = mem_pc[rd_ptr] + 32'd1;
    end
  end

endmodule
